// File: rtl/spi_pkg.sv
// Shared FSM encoding and default parameters for the SPI burst arbiter.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 255;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: search starts at the index after ptr and wraps.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int PTR_W = idx_width(DEF_NUM_REQ)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Shares one SPI master byte port among NUM_REQ requesters, one burst at a time,
// with round-robin grant and a per-byte RX timeout.
module spi_burst_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                            i_master_clk,
  input  logic                            i_master_rst_n,
  input  logic [NUM_REQ-1:0]              i_REQ,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]   i_REQ_LEN,
  input  logic [NUM_REQ-1:0][7:0]         i_REQ_TX_BYTE,
  output logic [NUM_REQ-1:0]              o_GNT,
  output logic [NUM_REQ-1:0]              o_REQ_TX_POP,
  output logic [NUM_REQ-1:0]              o_REQ_RX_VALID,
  output logic [7:0]                      o_REQ_RX_BYTE,
  output logic [NUM_REQ-1:0]              o_REQ_DONE,
  output logic [NUM_REQ-1:0]              o_REQ_ERR,
  output logic                            o_SPI_TX_VALID,
  output logic [7:0]                      o_SPI_TX_BYTE,
  input  logic                            i_SPI_TX_READY,
  input  logic                            i_SPI_RX_VALID,
  input  logic [7:0]                      i_SPI_RX_BYTE
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int TOUT_W = $clog2(TIMEOUT + 1);

  arb_state_t          state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [IDX_W-1:0]    gnt_idx_reg, gnt_idx_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic [LEN_W-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [TOUT_W-1:0]   tout_cnt_reg, tout_cnt_next;
  logic                err_reg, err_next;

  logic [NUM_REQ-1:0]  valid_req;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic [LEN_W-1:0]    byte_inc;
  logic [TOUT_W-1:0]   tout_inc;

  // Zero-length requests are invisible to the arbiter, so they never win or move the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_valid
      assign valid_req[gi] = i_REQ[gi] && (i_REQ_LEN[gi] != '0);
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr_arbiter (
    .req (valid_req),
    .ptr (ptr_reg),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = IDX_W'(i);
    end
  end

  assign byte_inc = byte_cnt_reg + 1'b1;
  assign tout_inc = tout_cnt_reg + 1'b1;
  assign o_GNT    = gnt_reg;

  always_ff @(posedge i_master_clk or negedge i_master_rst_n) begin
    if (!i_master_rst_n) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      gnt_idx_reg  <= '0;
      ptr_reg      <= IDX_W'(NUM_REQ - 1);
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      tout_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      gnt_idx_reg  <= gnt_idx_next;
      ptr_reg      <= ptr_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      tout_cnt_reg <= tout_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    gnt_idx_next   = gnt_idx_reg;
    ptr_next       = ptr_reg;
    len_next       = len_reg;
    byte_cnt_next  = byte_cnt_reg;
    tout_cnt_next  = tout_cnt_reg;
    err_next       = err_reg;
    o_REQ_TX_POP   = '0;
    o_REQ_RX_VALID = '0;
    o_REQ_RX_BYTE  = '0;
    o_REQ_DONE     = '0;
    o_REQ_ERR      = '0;
    o_SPI_TX_VALID = 1'b0;
    o_SPI_TX_BYTE  = '0;

    case (state_reg)
      ST_IDLE: begin
        byte_cnt_next = '0;
        tout_cnt_next = '0;
        err_next      = 1'b0;
        if (valid_req != '0) begin
          gnt_next     = arb_gnt;
          gnt_idx_next = arb_idx;
          len_next     = i_REQ_LEN[arb_idx];
          state_next   = ST_SEND;
        end
      end

      ST_SEND: begin
        o_SPI_TX_VALID = 1'b1;
        o_SPI_TX_BYTE  = i_REQ_TX_BYTE[gnt_idx_reg];
        if (i_SPI_TX_READY) begin
          o_REQ_TX_POP  = gnt_reg;
          tout_cnt_next = '0;
          state_next    = ST_WAIT_RX;
        end
      end

      ST_WAIT_RX: begin
        // An RX byte on the last permitted cycle still wins over the timeout.
        if (i_SPI_RX_VALID) begin
          o_REQ_RX_VALID = gnt_reg;
          o_REQ_RX_BYTE  = i_SPI_RX_BYTE;
          byte_cnt_next  = byte_inc;
          state_next     = (byte_inc == len_reg) ? ST_DONE : ST_SEND;
        end else begin
          tout_cnt_next = tout_inc;
          if (tout_inc == TOUT_W'(TIMEOUT)) begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        o_REQ_DONE = gnt_reg;
        o_REQ_ERR  = err_reg ? gnt_reg : '0;
        gnt_next   = '0;
        ptr_next   = gnt_idx_reg;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter: drives inputs 1 time unit after each rising
// edge, samples outputs on the falling edge, and models a simple SPI slave.
module tb_spi_burst_arbiter;

  localparam int NUM_REQ = 2;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 20;

  logic                          i_master_clk = 1'b0;
  logic                          i_master_rst_n = 1'b0;
  logic [NUM_REQ-1:0]            i_REQ;
  logic [NUM_REQ-1:0][LEN_W-1:0] i_REQ_LEN;
  logic [NUM_REQ-1:0][7:0]       i_REQ_TX_BYTE;
  logic [NUM_REQ-1:0]            o_GNT, o_REQ_TX_POP, o_REQ_RX_VALID, o_REQ_DONE, o_REQ_ERR;
  logic [7:0]                    o_REQ_RX_BYTE, o_SPI_TX_BYTE, i_SPI_RX_BYTE;
  logic                          o_SPI_TX_VALID, i_SPI_TX_READY, i_SPI_RX_VALID;

  spi_burst_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_master_clk   (i_master_clk),
    .i_master_rst_n (i_master_rst_n),
    .i_REQ          (i_REQ),
    .i_REQ_LEN      (i_REQ_LEN),
    .i_REQ_TX_BYTE  (i_REQ_TX_BYTE),
    .o_GNT          (o_GNT),
    .o_REQ_TX_POP   (o_REQ_TX_POP),
    .o_REQ_RX_VALID (o_REQ_RX_VALID),
    .o_REQ_RX_BYTE  (o_REQ_RX_BYTE),
    .o_REQ_DONE     (o_REQ_DONE),
    .o_REQ_ERR      (o_REQ_ERR),
    .o_SPI_TX_VALID (o_SPI_TX_VALID),
    .o_SPI_TX_BYTE  (o_SPI_TX_BYTE),
    .i_SPI_TX_READY (i_SPI_TX_READY),
    .i_SPI_RX_VALID (i_SPI_RX_VALID),
    .i_SPI_RX_BYTE  (i_SPI_RX_BYTE)
  );

  always #5 i_master_clk = ~i_master_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]         tx_data [NUM_REQ][4];
  int                 tx_pos  [NUM_REQ];
  logic [7:0]         rx_data [8];
  int                 rx_rd;
  int                 rx_delay;
  bit                 slave_mute, stall_tx;
  logic [NUM_REQ-1:0] hold_mask;

  logic [7:0]         pop_log [16];
  logic [7:0]         rx_log  [16];
  int                 n_pop, n_rx, pop_cyc, done_cyc;
  logic [NUM_REQ-1:0] rx_who, done_v, err_v, first_gnt, gnt_seen;
  bit                 finished, bad_onehot, bad_txv, bad_pop, txv_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] all_outs();
    return {o_GNT, o_REQ_TX_POP, o_REQ_RX_VALID, o_REQ_RX_BYTE, o_REQ_DONE,
            o_REQ_ERR, o_SPI_TX_VALID, o_SPI_TX_BYTE};
  endfunction

  // Runs up to max_cyc cycles, acting as requesters and SPI slave, until a DONE pulse.
  task automatic run_burst(input int max_cyc);
    bit                 pend;
    int                 cnt;
    logic [NUM_REQ-1:0] last_pop;
    pend = 0; cnt = 0; last_pop = '0;
    n_pop = 0; n_rx = 0; pop_cyc = -1; done_cyc = -1; finished = 0;
    rx_who = '0; done_v = '0; err_v = '0; first_gnt = '0; gnt_seen = '0;
    bad_pop = 0; bad_txv = 0; txv_seen = 0;
    for (int c = 0; c < max_cyc && !finished; c++) begin
      @(posedge i_master_clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (last_pop[r]) tx_pos[r]++;
        i_REQ_TX_BYTE[r] = tx_data[r][tx_pos[r] % 4];
      end
      i_SPI_TX_READY = stall_tx ? ((c % 2) == 1) : 1'b1;
      i_SPI_RX_VALID = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          i_SPI_RX_VALID = 1'b1;
          i_SPI_RX_BYTE  = rx_data[rx_rd % 8];
          rx_rd++;
          pend = 0;
        end else begin
          cnt--;
        end
      end

      @(negedge i_master_clk);
      last_pop = o_REQ_TX_POP;
      gnt_seen |= o_GNT;
      if (first_gnt == '0) first_gnt = o_GNT;
      if ((o_GNT & (o_GNT - 1'b1)) != '0) bad_onehot = 1;
      txv_seen |= o_SPI_TX_VALID;
      if (o_SPI_TX_VALID && o_GNT == '0) bad_txv = 1;
      if (o_REQ_TX_POP != '0) begin
        if (!(o_SPI_TX_VALID && i_SPI_TX_READY) || o_REQ_TX_POP != o_GNT) bad_pop = 1;
        if (n_pop < 16) pop_log[n_pop] = o_SPI_TX_BYTE;
        n_pop++;
        if (pop_cyc < 0) pop_cyc = c;
        if (!slave_mute) begin
          pend = 1;
          cnt  = rx_delay;
        end
      end
      if (o_REQ_RX_VALID != '0) begin
        if (n_rx < 16) rx_log[n_rx] = o_REQ_RX_BYTE;
        n_rx++;
        rx_who |= o_REQ_RX_VALID;
      end
      if (o_REQ_DONE != '0) begin
        done_v   = o_REQ_DONE;
        err_v    = o_REQ_ERR;
        done_cyc = c;
        finished = 1;
      end
      // Requesters drop their request once granted unless held; the DUT must ignore it.
      i_REQ = i_REQ & ~(o_GNT & ~hold_mask);
    end
    i_SPI_RX_VALID = 1'b0;
    $display("burst: gnt=%b pops=%0d rx=%0d done=%b err=%b pop_cyc=%0d done_cyc=%0d",
             first_gnt, n_pop, n_rx, done_v, err_v, pop_cyc, done_cyc);
  endtask

  task automatic do_reset();
    @(negedge i_master_clk);
    i_master_rst_n = 1'b0;
    repeat (2) @(negedge i_master_clk);
    i_master_rst_n = 1'b1;
  endtask

  initial begin
    i_REQ = 2'b11; i_REQ_LEN = {4'd2, 4'd3}; i_REQ_TX_BYTE = '0;
    i_SPI_TX_READY = 1'b1; i_SPI_RX_VALID = 1'b1; i_SPI_RX_BYTE = 8'h77;
    slave_mute = 0; stall_tx = 0; hold_mask = '0; rx_delay = 1; rx_rd = 0;
    bad_onehot = 0;
    tx_data[0][0] = 8'hAA; tx_data[0][1] = 8'hBB; tx_data[0][2] = 8'hCC; tx_data[0][3] = 8'h0C;
    tx_data[1][0] = 8'h31; tx_data[1][1] = 8'h32; tx_data[1][2] = 8'h33; tx_data[1][3] = 8'h34;
    tx_pos[0] = 0; tx_pos[1] = 0;

    // Reset held with busy inputs: every output must be zero.
    repeat (3) @(negedge i_master_clk);
    chk("reset_outputs", 32'(all_outs()), 32'h0);
    i_REQ = '0; i_SPI_RX_VALID = 1'b0;
    i_master_rst_n = 1'b1;

    // Single burst: req0 len 3, AA BB CC out, DD EE FF back, TX ready stalls every other cycle.
    rx_data[0] = 8'hDD; rx_data[1] = 8'hEE; rx_data[2] = 8'hFF;
    rx_rd = 0; rx_delay = 2; stall_tx = 1;
    i_REQ_LEN[0] = 4'd3; i_REQ = 2'b01;
    run_burst(100);
    chk("single_finished", 32'(finished), 32'd1);
    chk("single_gnt", 32'(first_gnt), 32'h1);
    chk("single_pops", n_pop, 32'd3);
    chk("single_tx_bytes", {8'h0, pop_log[0], pop_log[1], pop_log[2]}, 32'hAABBCC);
    chk("single_rx_count", n_rx, 32'd3);
    chk("single_rx_bytes", {8'h0, rx_log[0], rx_log[1], rx_log[2]}, 32'hDDEEFF);
    chk("single_rx_index", 32'(rx_who), 32'h1);
    chk("single_done", 32'(done_v), 32'h1);
    chk("single_err", 32'(err_v), 32'h0);
    chk("single_pop_handshake", 32'(bad_pop), 32'd0);
    chk("single_txv_only_granted", 32'(bad_txv), 32'd0);
    stall_tx = 0; rx_delay = 1;

    // Stray RX strobe while IDLE must not reach any requester.
    @(posedge i_master_clk); #1;
    i_SPI_RX_VALID = 1'b1; i_SPI_RX_BYTE = 8'h5A;
    @(negedge i_master_clk);
    chk("stray_rx_valid", 32'(o_REQ_RX_VALID), 32'h0);
    chk("stray_rx_byte", 32'(o_REQ_RX_BYTE), 32'h0);
    i_SPI_RX_VALID = 1'b0;

    // Contention from reset: both request together, req0 wins first.
    do_reset();
    tx_pos[0] = 0; tx_pos[1] = 0;
    rx_data[0] = 8'h11; rx_data[1] = 8'h22; rx_data[2] = 8'h33; rx_rd = 0;
    i_REQ_LEN = {4'd2, 4'd1}; i_REQ = 2'b11;
    run_burst(100);
    chk("cont_first_gnt", 32'(first_gnt), 32'h1);
    chk("cont_first_done", 32'(done_v), 32'h1);
    chk("cont_first_rx", 32'(rx_log[0]), 32'h11);
    run_burst(100);
    chk("cont_second_gnt", 32'(first_gnt), 32'h2);
    chk("cont_second_gnt_only", 32'(gnt_seen), 32'h2);
    chk("cont_second_done", 32'(done_v), 32'h2);
    chk("cont_second_tx", {16'h0, pop_log[0], pop_log[1]}, 32'h3132);
    chk("cont_second_rx", {16'h0, rx_log[0], rx_log[1]}, 32'h2233);
    chk("cont_onehot", 32'(bad_onehot), 32'd0);

    // Fairness: req0 held continuously, req1 pulses once -> grants 0,1,0.
    hold_mask = 2'b01; i_REQ_LEN = {4'd1, 4'd1}; i_REQ = 2'b01; rx_rd = 0;
    run_burst(100);
    chk("fair_gnt_a", 32'(first_gnt), 32'h1);
    i_REQ[1] = 1'b1;
    run_burst(100);
    chk("fair_gnt_b", 32'(first_gnt), 32'h2);
    run_burst(100);
    chk("fair_gnt_c", 32'(first_gnt), 32'h1);
    i_REQ = '0; hold_mask = '0;

    // Zero-length request from req1 is never served.
    i_REQ_LEN[1] = 4'd0; i_REQ = 2'b10;
    run_burst(30);
    chk("zero_len_finished", 32'(finished), 32'd0);
    chk("zero_len_gnt", 32'(gnt_seen), 32'h0);
    chk("zero_len_txv", 32'(txv_seen), 32'd0);
    i_REQ = '0;

    // Timeout: WAIT_RX lasts TIMEOUT cycles after the pop cycle, DONE+ERR on the next one.
    slave_mute = 1; i_REQ_LEN[0] = 4'd2; i_REQ = 2'b01;
    run_burst(100);
    chk("tout_done", 32'(done_v), 32'h1);
    chk("tout_err", 32'(err_v), 32'h1);
    chk("tout_pops", n_pop, 32'd1);
    chk("tout_rx", n_rx, 32'd0);
    chk("tout_latency", done_cyc - pop_cyc, TIMEOUT + 1);
    @(posedge i_master_clk); #1;
    @(negedge i_master_clk);
    chk("tout_back_idle", {o_GNT, o_SPI_TX_VALID, o_REQ_DONE}, 32'h0);
    slave_mute = 0;

    // RX on the last permitted WAIT_RX cycle is accepted without error.
    rx_delay = TIMEOUT; rx_data[0] = 8'h5C; rx_rd = 0;
    i_REQ_LEN[0] = 4'd1; i_REQ = 2'b01;
    run_burst(100);
    chk("edge_rx_done", 32'(done_v), 32'h1);
    chk("edge_rx_err", 32'(err_v), 32'h0);
    chk("edge_rx_byte", 32'(rx_log[0]), 32'h5C);
    rx_delay = 1;

    // Reset in WAIT_RX of a len-4 burst: outputs drop at once, no DONE.
    slave_mute = 1; i_REQ_LEN[0] = 4'd4; i_REQ = 2'b01;
    run_burst(3);
    chk("midrst_granted", 32'(o_GNT), 32'h1);
    i_master_rst_n = 1'b0;
    i_SPI_RX_VALID = 1'b1;
    #1;
    chk("midrst_outputs_now", 32'(all_outs()), 32'h0);
    @(negedge i_master_clk);
    chk("midrst_outputs_held", 32'(all_outs()), 32'h0);
    i_SPI_RX_VALID = 1'b0;
    i_master_rst_n = 1'b1;
    slave_mute = 0; tx_pos[0] = 0; rx_rd = 0;
    rx_data[0] = 8'hA1; rx_data[1] = 8'hA2; rx_data[2] = 8'hA3; rx_data[3] = 8'hA4;
    i_REQ = 2'b01;
    run_burst(100);
    chk("postrst_gnt", 32'(first_gnt), 32'h1);
    chk("postrst_done", 32'(done_v), 32'h1);
    chk("postrst_err", 32'(err_v), 32'h0);
    chk("postrst_rx_bytes", {rx_log[0], rx_log[1], rx_log[2], rx_log[3]}, 32'hA1A2A3A4);
    chk("postrst_onehot", 32'(bad_onehot), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
